hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Hazard control for a 5-stage pipeline: load-use bubbles, branch flushes,
// CALL/RET sequencing, memory freeze, plus a saturating bubble counter.
module hazard_control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ID_RsrcAddress,
  input  logic [2:0] ID_RdstAddress,
  input  logic       ID_usesRsrc,
  input  logic       ID_usesRdst,
  input  logic       ID_isCall,
  input  logic       ID_isRet,
  input  logic       EX_memRead,
  input  logic       EX_WB,
  input  logic [2:0] EX_RdstAddress,
  input  logic       EX_branchTaken,
  input  logic       memStall,
  output logic       stallPC,
  output logic       stallIF_ID,
  output logic       stallBuffer,
  output logic       flushIF_ID,
  output logic       Flush,
  output logic       loaduseCase,
  output logic       stallLD,
  output logic       ForwardPCHighCall,
  output logic       ForwardPCLowCall,
  output logic [2:0] state,
  output logic [7:0] bubbleCount
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    CALL2 = 3'd1,
    RET1  = 3'd2,
    RET2  = 3'd3,
    RET3  = 3'd4
  } hcu_state_e;

  hcu_state_e state_q, state_d;
  logic [7:0] bubble_cnt_q, bubble_cnt_d;
  logic       load_use_s;

  logic stall_pc_s, stall_if_id_s, stall_buffer_s, flush_if_id_s, flush_s;
  logic load_use_case_s, stall_ld_s, fwd_high_s, fwd_low_s;

  function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  assign load_use_s = EX_memRead & EX_WB &
                      ((ID_usesRsrc & (ID_RsrcAddress == EX_RdstAddress)) |
                       (ID_usesRdst & (ID_RdstAddress == EX_RdstAddress)));

  // Next-state, counter and control decode in priority order
  always_comb begin
    state_d         = state_q;
    bubble_cnt_d    = bubble_cnt_q;
    stall_pc_s      = 1'b0;
    stall_if_id_s   = 1'b0;
    stall_buffer_s  = 1'b0;
    flush_if_id_s   = 1'b0;
    flush_s         = 1'b0;
    load_use_case_s = 1'b0;
    stall_ld_s      = 1'b0;
    fwd_high_s      = 1'b0;
    fwd_low_s       = 1'b0;
    if (!rst_n) begin
      state_d      = RUN;
      bubble_cnt_d = 8'd0;
    end else if (memStall) begin
      stall_pc_s     = 1'b1;
      stall_if_id_s  = 1'b1;
      stall_buffer_s = 1'b1;
    end else if (EX_branchTaken) begin
      flush_if_id_s = 1'b1;
      flush_s       = 1'b1;
      state_d       = RUN;
      bubble_cnt_d  = sat_add(bubble_cnt_q, 2'd2);
    end else begin
      case (state_q)
        RUN: begin
          if (load_use_s) begin
            stall_pc_s      = 1'b1;
            stall_if_id_s   = 1'b1;
            stall_ld_s      = 1'b1;
            flush_s         = 1'b1;
            load_use_case_s = 1'b1;
            bubble_cnt_d    = sat_add(bubble_cnt_q, 2'd1);
          end else if (ID_isCall) begin
            fwd_high_s    = 1'b1;
            stall_pc_s    = 1'b1;
            stall_if_id_s = 1'b1;
            state_d       = CALL2;
          end else if (ID_isRet) begin
            stall_pc_s    = 1'b1;
            flush_if_id_s = 1'b1;
            state_d       = RET1;
            bubble_cnt_d  = sat_add(bubble_cnt_q, 2'd1);
          end else begin
            state_d = RUN;
          end
        end
        CALL2: begin
          fwd_low_s = 1'b1;
          state_d   = RUN;
        end
        RET1, RET2: begin
          stall_pc_s    = 1'b1;
          flush_if_id_s = 1'b1;
          state_d       = (state_q == RET1) ? RET2 : RET3;
          bubble_cnt_d  = sat_add(bubble_cnt_q, 2'd1);
        end
        RET3: begin
          // PC is released here so the popped return address loads
          flush_if_id_s = 1'b1;
          state_d       = RUN;
          bubble_cnt_d  = sat_add(bubble_cnt_q, 2'd1);
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State and bubble counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      bubble_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stallPC           = stall_pc_s;
  assign stallIF_ID        = stall_if_id_s;
  assign stallBuffer       = stall_buffer_s;
  assign flushIF_ID        = flush_if_id_s;
  assign Flush             = flush_s;
  assign loaduseCase       = load_use_case_s;
  assign stallLD           = stall_ld_s;
  assign ForwardPCHighCall = fwd_high_s;
  assign ForwardPCLowCall  = fwd_low_s;
  assign state             = state_q;
  assign bubbleCount       = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit; control outputs are packed as
// {stallPC,stallIF_ID,stallBuffer,flushIF_ID,Flush,loaduseCase,stallLD,FwdHigh,FwdLow}.
module tb_hazard_control_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] ID_RsrcAddress, ID_RdstAddress, EX_RdstAddress;
  logic       ID_usesRsrc, ID_usesRdst, ID_isCall, ID_isRet;
  logic       EX_memRead, EX_WB, EX_branchTaken, memStall;
  logic       stallPC, stallIF_ID, stallBuffer, flushIF_ID, Flush;
  logic       loaduseCase, stallLD, ForwardPCHighCall, ForwardPCLowCall;
  logic [2:0] state;
  logic [7:0] bubbleCount;

  int n_cmp;
  int n_bad;

  localparam logic [8:0] CTL_NONE  = 9'b000000000;
  localparam logic [8:0] CTL_LU    = 9'b110011100;
  localparam logic [8:0] CTL_MEM   = 9'b111000000;
  localparam logic [8:0] CTL_BR    = 9'b000110000;
  localparam logic [8:0] CTL_CALL1 = 9'b110000010;
  localparam logic [8:0] CTL_CALL2 = 9'b000000001;
  localparam logic [8:0] CTL_RET   = 9'b100100000;
  localparam logic [8:0] CTL_RET3  = 9'b000100000;

  hazard_control_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ID_RsrcAddress(ID_RsrcAddress), .ID_RdstAddress(ID_RdstAddress),
    .ID_usesRsrc(ID_usesRsrc), .ID_usesRdst(ID_usesRdst),
    .ID_isCall(ID_isCall), .ID_isRet(ID_isRet),
    .EX_memRead(EX_memRead), .EX_WB(EX_WB), .EX_RdstAddress(EX_RdstAddress),
    .EX_branchTaken(EX_branchTaken), .memStall(memStall),
    .stallPC(stallPC), .stallIF_ID(stallIF_ID), .stallBuffer(stallBuffer),
    .flushIF_ID(flushIF_ID), .Flush(Flush), .loaduseCase(loaduseCase),
    .stallLD(stallLD), .ForwardPCHighCall(ForwardPCHighCall),
    .ForwardPCLowCall(ForwardPCLowCall), .state(state), .bubbleCount(bubbleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctl();
    return {stallPC, stallIF_ID, stallBuffer, flushIF_ID, Flush,
            loaduseCase, stallLD, ForwardPCHighCall, ForwardPCLowCall};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_RsrcAddress = 3'd0; ID_RdstAddress = 3'd0; EX_RdstAddress = 3'd0;
    ID_usesRsrc = 1'b0; ID_usesRdst = 1'b0; ID_isCall = 1'b0; ID_isRet = 1'b0;
    EX_memRead = 1'b0; EX_WB = 1'b0; EX_branchTaken = 1'b0; memStall = 1'b0;
  endtask

  // Advance to the next falling edge, then let combinational outputs settle
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_inputs();
    rst_n = 1'b0;

    // Reset: outputs gated even with hazards present
    next_cycle();
    memStall = 1'b1; EX_branchTaken = 1'b1; ID_isCall = 1'b1;
    settle();
    check("rst_ctl", {23'd0, ctl()}, {23'd0, CTL_NONE});
    next_cycle();
    clear_inputs();
    settle();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_bubble", {24'd0, bubbleCount}, 32'd0);
    rst_n = 1'b1;
    settle();
    check("idle_ctl", {23'd0, ctl()}, {23'd0, CTL_NONE});

    // Load-use on Rsrc
    next_cycle();
    EX_memRead = 1'b1; EX_WB = 1'b1; EX_RdstAddress = 3'd3;
    ID_RsrcAddress = 3'd3; ID_usesRsrc = 1'b1;
    settle();
    check("lu_ctl", {23'd0, ctl()}, {23'd0, CTL_LU});
    next_cycle();
    clear_inputs();
    settle();
    check("lu_bubble", {24'd0, bubbleCount}, 32'd1);
    check("lu_one_cycle", {23'd0, ctl()}, {23'd0, CTL_NONE});

    // Same addresses, no register use: no stall
    EX_memRead = 1'b1; EX_WB = 1'b1; EX_RdstAddress = 3'd3;
    ID_RsrcAddress = 3'd3; ID_RdstAddress = 3'd3;
    settle();
    check("nouse_ctl", {23'd0, ctl()}, {23'd0, CTL_NONE});
    next_cycle();
    settle();
    check("nouse_bubble", {24'd0, bubbleCount}, 32'd1);

    // R0 via Rdst is an ordinary register
    clear_inputs();
    EX_memRead = 1'b1; EX_WB = 1'b1; EX_RdstAddress = 3'd0;
    ID_RdstAddress = 3'd0; ID_usesRdst = 1'b1; ID_RsrcAddress = 3'd5; ID_usesRsrc = 1'b1;
    settle();
    check("r0_ctl", {23'd0, ctl()}, {23'd0, CTL_LU});
    next_cycle();
    clear_inputs();
    // EX_WB=0 blocks detection
    EX_memRead = 1'b1; EX_RdstAddress = 3'd2; ID_RsrcAddress = 3'd2; ID_usesRsrc = 1'b1;
    settle();
    check("r0_bubble", {24'd0, bubbleCount}, 32'd2);
    check("nowb_ctl", {23'd0, ctl()}, {23'd0, CTL_NONE});

    // Load-use beats CALL; CALL starts next cycle
    EX_WB = 1'b1; ID_isCall = 1'b1;
    settle();
    check("lu_vs_call", {23'd0, ctl()}, {23'd0, CTL_LU});
    next_cycle();
    EX_memRead = 1'b0; EX_WB = 1'b0;
    settle();
    check("lu_vs_call_state", {29'd0, state}, 32'd0);
    check("call1_ctl", {23'd0, ctl()}, {23'd0, CTL_CALL1});
    next_cycle();
    clear_inputs();
    settle();
    check("call2_state", {29'd0, state}, 32'd1);
    check("call2_ctl", {23'd0, ctl()}, {23'd0, CTL_CALL2});
    next_cycle();
    settle();
    check("call_done_state", {29'd0, state}, 32'd0);
    check("call_bubble", {24'd0, bubbleCount}, 32'd3);

    // CALL+RET together behaves as CALL, then memStall held 3 cycles in CALL2
    ID_isCall = 1'b1; ID_isRet = 1'b1;
    settle();
    check("callret_ctl", {23'd0, ctl()}, {23'd0, CTL_CALL1});
    next_cycle();
    clear_inputs();
    memStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("mem_ctl%0d", i), {23'd0, ctl()}, {23'd0, CTL_MEM});
      check($sformatf("mem_state%0d", i), {29'd0, state}, 32'd1);
      next_cycle();
    end
    memStall = 1'b0;
    settle();
    check("mem_release_ctl", {23'd0, ctl()}, {23'd0, CTL_CALL2});
    next_cycle();
    settle();
    check("mem_release_state", {29'd0, state}, 32'd0);
    check("mem_bubble", {24'd0, bubbleCount}, 32'd3);

    // memStall beats branch: no flush, bubble count holds
    memStall = 1'b1; EX_branchTaken = 1'b1;
    settle();
    check("mem_vs_br_ctl", {23'd0, ctl()}, {23'd0, CTL_MEM});
    next_cycle();
    clear_inputs();
    settle();
    check("mem_vs_br_bubble", {24'd0, bubbleCount}, 32'd3);

    // RET aborted by a branch in RET2
    ID_isRet = 1'b1;
    settle();
    check("ret0_ctl", {23'd0, ctl()}, {23'd0, CTL_RET});
    next_cycle();
    clear_inputs();
    settle();
    check("ret1_state", {29'd0, state}, 32'd2);
    check("ret1_ctl", {23'd0, ctl()}, {23'd0, CTL_RET});
    next_cycle();
    EX_branchTaken = 1'b1;
    settle();
    check("ret2_state", {29'd0, state}, 32'd3);
    check("ret2_br_ctl", {23'd0, ctl()}, {23'd0, CTL_BR});
    next_cycle();
    clear_inputs();
    settle();
    check("ret_abort_state", {29'd0, state}, 32'd0);
    check("ret_abort_ctl", {23'd0, ctl()}, {23'd0, CTL_NONE});

    // Full RET sequence
    ID_isRet = 1'b1;
    next_cycle();
    clear_inputs();
    next_cycle();
    settle();
    check("ret_full_ret2", {29'd0, state}, 32'd3);
    check("ret_full_ret2_ctl", {23'd0, ctl()}, {23'd0, CTL_RET});
    next_cycle();
    settle();
    check("ret3_state", {29'd0, state}, 32'd4);
    check("ret3_ctl", {23'd0, ctl()}, {23'd0, CTL_RET3});
    next_cycle();
    settle();
    check("ret_done_state", {29'd0, state}, 32'd0);

    // Reset mid-CALL abandons the sequence
    ID_isCall = 1'b1;
    next_cycle();
    clear_inputs();
    rst_n = 1'b0;
    settle();
    check("rst_call2_ctl", {23'd0, ctl()}, {23'd0, CTL_NONE});
    next_cycle();
    rst_n = 1'b1;
    settle();
    check("rst_call2_state", {29'd0, state}, 32'd0);
    check("rst_call2_nolow", {23'd0, ctl()}, {23'd0, CTL_NONE});
    check("rst_call2_bubble", {24'd0, bubbleCount}, 32'd0);

    // Saturation through branch flushes
    EX_branchTaken = 1'b1;
    settle();
    check("br_ctl", {23'd0, ctl()}, {23'd0, CTL_BR});
    for (int i = 0; i < 127; i++) next_cycle();
    settle();
    check("sat_254", {24'd0, bubbleCount}, 32'd254);
    next_cycle();
    settle();
    check("sat_255", {24'd0, bubbleCount}, 32'd255);
    next_cycle();
    next_cycle();
    clear_inputs();
    settle();
    check("sat_hold", {24'd0, bubbleCount}, 32'd255);
    rst_n = 1'b0;
    next_cycle();
    settle();
    check("sat_rst_bubble", {24'd0, bubbleCount}, 32'd0);
    check("sat_rst_state", {29'd0, state}, 32'd0);
    check("sat_rst_ctl", {23'd0, ctl()}, {23'd0, CTL_NONE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
